// File: rtl/xbar_bank_req_arb_if.sv
// xbar_bank_req_arb_if: channel request side and per-bank request side of the crossbar
interface xbar_bank_req_arb_if;
  logic [3:0]   ch_htu_valid;
  logic [3:0]   ch_htu_allowIn;
  logic [7:0]   ch_htu_opcode;
  logic [111:0] ch_htu_addr;
  logic [31:0]  ch_htu_wbuffer_id;
  logic [3:0]   xbar_bank_htu_valid;
  logic [3:0]   xbar_bank_htu_allowIn;
  logic [7:0]   xbar_bank_htu_ch_id;
  logic [7:0]   xbar_bank_htu_opcode;
  logic [111:0] xbar_bank_htu_addr;
  logic [31:0]  xbar_bank_htu_wbuffer_id;
  modport master (
    output ch_htu_valid, ch_htu_opcode, ch_htu_addr, ch_htu_wbuffer_id, xbar_bank_htu_allowIn,
    input  ch_htu_allowIn, xbar_bank_htu_valid, xbar_bank_htu_ch_id, xbar_bank_htu_opcode,
           xbar_bank_htu_addr, xbar_bank_htu_wbuffer_id
  );
  modport slave (
    input  ch_htu_valid, ch_htu_opcode, ch_htu_addr, ch_htu_wbuffer_id, xbar_bank_htu_allowIn,
    output ch_htu_allowIn, xbar_bank_htu_valid, xbar_bank_htu_ch_id, xbar_bank_htu_opcode,
           xbar_bank_htu_addr, xbar_bank_htu_wbuffer_id
  );
endinterface

// File: rtl/xbar_bank_req_arb.sv
// xbar_bank_req_arb: 4-channel to 4-bank request crossbar with per-bank round-robin and output register
module xbar_bank_req_arb #(
  parameter int NUM_CH       = 4,
  parameter int NUM_BANK     = 4,
  parameter int BANK_SEL_LSB = 5
) (
  input logic                clk_i,
  input logic                rst_i,
  xbar_bank_req_arb_if.slave bus
);
  // addr carries addr[31:4], so full-address bit n sits at field bit n-4
  localparam int SEL_OFF = BANK_SEL_LSB - 4;
  logic [1:0]   sel [NUM_CH];
  logic [1:0]   win [NUM_BANK];
  logic [1:0]   rr_ptr [NUM_BANK];
  logic [1:0]   idx;
  logic [3:0]   hit, ld, allow;
  logic [3:0]   valid_q;
  logic [7:0]   ch_id_q, opcode_q;
  logic [111:0] addr_q;
  logic [31:0]  wbid_q;
  // bank select, round-robin winner per bank and combinational channel accept
  always_comb begin
    idx   = '0;
    allow = '0;
    for (int c = 0; c < NUM_CH; c++) sel[c] = bus.ch_htu_addr[28*c+SEL_OFF +: 2];
    for (int b = 0; b < NUM_BANK; b++) begin
      hit[b] = 1'b0;
      win[b] = '0;
      ld[b]  = !valid_q[b] || bus.xbar_bank_htu_allowIn[b];
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = rr_ptr[b] + 2'(k);
        if (bus.ch_htu_valid[idx] && sel[idx] == 2'(b)) begin
          hit[b] = 1'b1;
          win[b] = idx;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      allow[c] = !rst_i && ld[sel[c]] && hit[sel[c]] && win[sel[c]] == 2'(c);
  end
  // per-bank pipeline register; loads the winner, or empties when drained with no requester
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      ch_id_q  <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      wbid_q   <= '0;
      for (int b = 0; b < NUM_BANK; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (ld[b]) begin
          valid_q[b] <= hit[b];
          if (hit[b]) begin
            ch_id_q[2*b +: 2]  <= win[b];
            opcode_q[2*b +: 2] <= bus.ch_htu_opcode[2*win[b] +: 2];
            addr_q[28*b +: 28] <= bus.ch_htu_addr[28*win[b] +: 28];
            wbid_q[8*b +: 8]   <= bus.ch_htu_wbuffer_id[8*win[b] +: 8];
            rr_ptr[b]          <= win[b] + 2'd1;
          end
        end
      end
    end
  end
  assign bus.ch_htu_allowIn           = allow;
  assign bus.xbar_bank_htu_valid      = valid_q;
  assign bus.xbar_bank_htu_ch_id      = ch_id_q;
  assign bus.xbar_bank_htu_opcode     = opcode_q;
  assign bus.xbar_bank_htu_addr       = addr_q;
  assign bus.xbar_bank_htu_wbuffer_id = wbid_q;
endmodule
